// File: rtl/rc4_prga_core.sv
// RC4 keystream generator / single-message decrypt engine with start/done handshake and abort.
// Optional macro RC4_CHARSET_EXT_EN widens the accepted plaintext set (upper case, digits, 0x21..0x2F).
module rc4_prga_core #(
    parameter int MSG_LEN = 32,
    parameter int RD_LAT  = 2,
    parameter int K_W     = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic           abort,
    input  logic           check_bypass,
    input  logic [7:0]     q_data,
    output logic           mem_req,
    output logic [1:0]     mem_sel,
    output logic [7:0]     addr,
    output logic [7:0]     wdata,
    output logic           wen,
    output logic           busy,
    output logic           done,
    output logic [1:0]     result,
    output logic [K_W-1:0] k_out
);

    typedef enum logic [3:0] {
        IDLE, INC_I, RD_SI, ADD_J, RD_SJ, WR_I, WR_J, RD_F, RD_CT, WR_PT, CHK, FAIL, DONE
    } state_t;

    localparam logic [1:0]     SEL_NONE = 2'd0;
    localparam logic [1:0]     SEL_S    = 2'd1;
    localparam logic [1:0]     SEL_ROM  = 2'd2;
    localparam logic [1:0]     SEL_RAM  = 2'd3;
    localparam logic [2:0]     LAT      = 3'(RD_LAT);
    localparam logic [K_W-1:0] K_LAST   = K_W'(MSG_LEN - 1);

    state_t         state, state_n;
    logic [7:0]     i, i_n, j, j_n, si, si_n, sj, sj_n, f, f_n, ct, ct_n, pt, pt_n;
    logic [K_W-1:0] k, k_n;
    logic [2:0]     cnt, cnt_n;
    logic [1:0]     result_n, mem_sel_n;
    logic [7:0]     addr_n, wdata_n;
    logic           wen_n, busy_n, done_n, rd_last;

    function automatic logic in_charset(input logic [7:0] b);
        logic ok;
        ok = (b >= 8'h61 && b <= 8'h7A) || (b == 8'h20);
`ifdef RC4_CHARSET_EXT_EN
        ok = ok || (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h30 && b <= 8'h39) ||
             (b >= 8'h21 && b <= 8'h2F);
`endif
        return ok;
    endfunction

    // A read state lasts 1+RD_LAT cycles; q_data is captured on its final cycle.
    assign rd_last = (cnt == LAT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            si      <= '0;
            sj      <= '0;
            f       <= '0;
            ct      <= '0;
            pt      <= '0;
            cnt     <= '0;
            result  <= '0;
            mem_req <= 1'b0;
            mem_sel <= '0;
            addr    <= '0;
            wdata   <= '0;
            wen     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            k_out   <= '0;
        end else begin
            state   <= state_n;
            i       <= i_n;
            j       <= j_n;
            k       <= k_n;
            si      <= si_n;
            sj      <= sj_n;
            f       <= f_n;
            ct      <= ct_n;
            pt      <= pt_n;
            cnt     <= cnt_n;
            result  <= result_n;
            mem_req <= busy_n;
            mem_sel <= mem_sel_n;
            addr    <= addr_n;
            wdata   <= wdata_n;
            wen     <= wen_n;
            busy    <= busy_n;
            done    <= done_n;
            k_out   <= k_n;
        end
    end

    always_comb begin
        state_n  = state;
        i_n      = i;
        j_n      = j;
        k_n      = k;
        si_n     = si;
        sj_n     = sj;
        f_n      = f;
        ct_n     = ct;
        pt_n     = pt;
        cnt_n    = 3'd0;
        result_n = result;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n  = INC_I;
                    i_n      = 8'd0;
                    j_n      = 8'd0;
                    k_n      = '0;
                    result_n = 2'b00;
                end
            end
            INC_I: begin
                i_n     = i + 8'd1;
                state_n = RD_SI;
            end
            RD_SI: begin
                if (rd_last) begin
                    si_n    = q_data;
                    state_n = ADD_J;
                end else cnt_n = cnt + 3'd1;
            end
            ADD_J: begin
                j_n     = j + si;
                state_n = RD_SJ;
            end
            RD_SJ: begin
                if (rd_last) begin
                    sj_n    = q_data;
                    state_n = WR_I;
                end else cnt_n = cnt + 3'd1;
            end
            WR_I: state_n = WR_J;
            WR_J: state_n = RD_F;
            RD_F: begin
                if (rd_last) begin
                    f_n     = q_data;
                    state_n = RD_CT;
                end else cnt_n = cnt + 3'd1;
            end
            RD_CT: begin
                if (rd_last) begin
                    ct_n    = q_data;
                    state_n = WR_PT;
                end else cnt_n = cnt + 3'd1;
            end
            WR_PT: begin
                pt_n    = f ^ ct;
                state_n = CHK;
            end
            CHK: begin
                if (!(check_bypass || in_charset(pt))) begin
                    state_n  = FAIL;
                    result_n = 2'b10;
                end else if (k == K_LAST) begin
                    state_n  = DONE;
                    result_n = 2'b01;
                end else if (abort) begin
                    state_n  = DONE;
                    result_n = 2'b11;
                end else begin
                    k_n     = k + 1'b1;
                    state_n = INC_I;
                end
            end
            FAIL:    state_n = DONE;
            default: state_n = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered copies line up with it.
        mem_sel_n = SEL_NONE;
        addr_n    = 8'd0;
        wdata_n   = 8'd0;
        wen_n     = 1'b0;
        busy_n    = (state_n != IDLE) && (state_n != DONE);
        done_n    = (state_n == DONE);
        unique case (state_n)
            RD_SI: begin mem_sel_n = SEL_S; addr_n = i_n; end
            RD_SJ: begin mem_sel_n = SEL_S; addr_n = j_n; end
            WR_I:  begin mem_sel_n = SEL_S; addr_n = i_n; wdata_n = sj_n; wen_n = 1'b1; end
            WR_J:  begin mem_sel_n = SEL_S; addr_n = j_n; wdata_n = si_n; wen_n = 1'b1; end
            RD_F:  begin mem_sel_n = SEL_S; addr_n = si_n + sj_n; end
            RD_CT: begin mem_sel_n = SEL_ROM; addr_n = 8'(k_n); end
            WR_PT: begin mem_sel_n = SEL_RAM; addr_n = 8'(k_n); wdata_n = f_n ^ ct_n; wen_n = 1'b1; end
            default: ;
        endcase
    end

endmodule
